// File: rtl/cla_addsub_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined CLA adder/subtractor:
//   - op encodings presented on the operand-side bus
//   - flag bundle produced alongside each result
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe_if
// Operand-side and result-side handshake bundle for cla_addsub_pipe.
//   in_valid/in_ready     : operand handshake (a, b, op, cin)
//   out_valid/out_ready   : result handshake (f, c, v, z, n)
// master : operand producer / result consumer (datapath around the block)
// slave  : the adder/subtractor itself
// -----------------------------------------------------------------------------
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c;
  logic             v;
  logic             z;
  logic             n;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, f, c, v, z, n
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, f, c, v, z, n
  );

endinterface

// File: rtl/cla4_group.sv
// -----------------------------------------------------------------------------
// cla4_group
// Combinational 4-bit carry-lookahead group.
//   a, b : 4-bit operands
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
//   g, p : group generate / propagate
// -----------------------------------------------------------------------------
module cla4_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       g,
  output logic       p
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  assign c[0] = ci;
  assign c[1] = gen[0] | (prop[0] & ci);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & ci);

  assign g  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p  = &prop;
  assign co = g | (p & ci);

  assign s = prop ^ c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
// Pipelined ADD/ADC/SUB/SBB unit. Operands are conditioned and registered on
// accept, then each stage adds one SW-bit slice (GPS chained CLA groups) and
// hands its carry to the next stage, so the carry ripples across cycles.
// Latency is STAGES cycles after the accept edge; one result per cycle.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : cla_addsub_pipe_if.slave (operand and result handshakes)
// Parameters: WIDTH (multiple of 4*GPS), GPS (CLA groups per stage, >= 1).
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  cla_addsub_pipe_if.slave bus
);

  import cla_pkg::*;

  localparam int SW     = 4 * GPS;
  localparam int STAGES = (GPS < 1) ? 1 : WIDTH / SW;

  if ((GPS < 1) || ((WIDTH % (4 * GPS)) != 0)) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a nonzero multiple of 4*GPS and GPS >= 1");
  end

  // Global enable: the whole pipe moves together; bubbles stay in place.
  logic adv;
  assign adv          = ~g_stage[STAGES-1].vld_q | bus.out_ready;
  assign bus.in_ready = adv;

  // Operand conditioning: subtraction is A + ~B + carry.
  logic             sub_op;
  logic             use_cin;
  logic             carry_in;
  logic [WIDTH-1:0] bx;

  assign sub_op   = (bus.op == OP_SUB) || (bus.op == OP_SBB);
  assign use_cin  = (bus.op == OP_ADC) || (bus.op == OP_SBB);
  assign carry_in = use_cin ? bus.cin : sub_op;
  assign bx       = sub_op ? ~bus.b : bus.b;

  logic             in_vld_q;
  logic             in_cy_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q <= 1'b0;
      in_cy_q  <= 1'b0;
      in_a_q   <= '0;
      in_b_q   <= '0;
    end else if (adv) begin
      in_vld_q <= bus.in_valid;
      in_cy_q  <= carry_in;
      in_a_q   <= bus.a;
      in_b_q   <= bx;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet summed shrink by one slice per stage; bit 0 of
    // a_i/b_i is always bit k*SW of the original operand.
    localparam int REM = WIDTH - k * SW;

    logic             vld_i;
    logic             cy_i;
    logic [REM-1:0]   a_i;
    logic [REM-1:0]   b_i;
    logic [WIDTH-1:0] sum_i;

    if (k == 0) begin : g_src_in
      assign vld_i = in_vld_q;
      assign cy_i  = in_cy_q;
      assign a_i   = in_a_q;
      assign b_i   = in_b_q;
      assign sum_i = '0;
    end else begin : g_src_prev
      assign vld_i = g_stage[k-1].vld_q;
      assign cy_i  = g_stage[k-1].cy_q;
      assign a_i   = g_stage[k-1].g_fwd.a_q;
      assign b_i   = g_stage[k-1].g_fwd.b_q;
      assign sum_i = g_stage[k-1].sum_q;
    end

    logic [GPS:0]     gc;
    logic [SW-1:0]    s;
    logic [GPS-1:0]   unused_g;
    logic [GPS-1:0]   unused_p;
    logic [WIDTH-1:0] nxt_sum;

    assign gc[0] = cy_i;

    for (genvar gi = 0; gi < GPS; gi++) begin : g_grp
      cla4_group u_grp (
        .a  (a_i[gi*4 +: 4]),
        .b  (b_i[gi*4 +: 4]),
        .ci (gc[gi]),
        .s  (s[gi*4 +: 4]),
        .co (gc[gi+1]),
        .g  (unused_g[gi]),
        .p  (unused_p[gi])
      );
    end

    always_comb begin
      nxt_sum             = sum_i;
      nxt_sum[k*SW +: SW] = s;
    end

    logic             vld_q;
    logic             cy_q;
    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_i;
        cy_q  <= gc[GPS];
        sum_q <= nxt_sum;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_i[REM-1:SW];
          b_q <= b_i[REM-1:SW];
        end
      end
    end
  end

  // Carry into the MSB is recovered from the MSB sum: s = a ^ b ^ cin.
  localparam int L = STAGES - 1;

  logic   msb_cin;
  flags_t nxt_flags;
  flags_t flags_q;

  assign msb_cin = g_stage[L].a_i[SW-1] ^ g_stage[L].b_i[SW-1] ^ g_stage[L].s[SW-1];

  always_comb begin
    nxt_flags.c = g_stage[L].gc[GPS];
    nxt_flags.v = msb_cin ^ g_stage[L].gc[GPS];
    nxt_flags.z = ~|g_stage[L].nxt_sum;
    nxt_flags.n = g_stage[L].nxt_sum[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (adv) begin
      flags_q <= nxt_flags;
    end
  end

  assign bus.out_valid = g_stage[L].vld_q;
  assign bus.f         = g_stage[L].sum_q;
  assign bus.c         = flags_q.c;
  assign bus.v         = flags_q.v;
  assign bus.z         = flags_q.z;
  assign bus.n         = flags_q.n;

endmodule
